// File: rtl/dual_rail_pkg.sv
// dual_rail_pkg: shared state encoding and symbol definitions for the dual-rail receiver
package dual_rail_pkg;
  typedef enum logic {COLLECT, HOLD} state_t;
  localparam logic [1:0] SYM_ONE = 2'b10;
  localparam logic [1:0] SYM_ZERO = 2'b01;
  function automatic logic is_valid_sym(input logic [1:0] sym);
    return sym == SYM_ONE || sym == SYM_ZERO;
  endfunction
endpackage

// File: rtl/dual_rail_sym_check.sv
// dual_rail_sym_check: decodes a {rail_p,rail_n} symbol into a data bit and a validity flag
module dual_rail_sym_check
  import dual_rail_pkg::*;
(
  input  logic rail_p,
  input  logic rail_n,
  output logic bit_val,
  output logic sym_ok
);
  assign bit_val = {rail_p, rail_n} == SYM_ONE;
  assign sym_ok = is_valid_sym({rail_p, rail_n});
endmodule

// File: rtl/dual_rail_receiver.sv
// dual_rail_receiver: deserialises dual-rail symbols LSB-first into words with invalid-symbol counting
module dual_rail_receiver
  import dual_rail_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sof,
  input  logic                 rail_p,
  input  logic                 rail_n,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state, state_nxt;
  logic [CW-1:0] bit_cnt;
  logic [WIDTH-1:0] shift, shift_nxt, one;
  logic bit_val, sym_ok, acc, good, done;
  dual_rail_sym_check u_sym (
    .rail_p (rail_p),
    .rail_n (rail_n),
    .bit_val(bit_val),
    .sym_ok (sym_ok)
  );
  assign acc = in_valid && in_ready;
  assign good = acc && sym_ok;
  assign done = good && !in_sof && bit_cnt == LAST;
  assign one = {{(WIDTH-1){1'b0}}, 1'b1};
  assign shift_nxt = in_sof ? (bit_val ? one : '0)
                            : ((shift & ~(one << bit_cnt)) | ({WIDTH{bit_val}} & (one << bit_cnt)));
  always_ff @(posedge clk)
    if (reset) state <= COLLECT;
    else state <= state_nxt;
  always_comb
    state_nxt = state == COLLECT ? (done ? HOLD : COLLECT) : (out_ready ? COLLECT : HOLD);
  always_comb
    in_ready = state == COLLECT;
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt <= '0;
      shift <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= acc && !sym_ok;
      if (acc && !sym_ok) begin
        bit_cnt <= '0;
        if (err_count != '1) err_count <= err_count + 1'b1;
      end else if (good) begin
        shift <= shift_nxt;
        bit_cnt <= done ? '0 : (in_sof ? CW'(1) : bit_cnt + 1'b1);
      end
      if (done) begin
        out_data <= shift_nxt;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dual_rail_receiver.sv
// tb_dual_rail_receiver: scoreboard bench for dual_rail_receiver with directed word and error vectors
module tb_dual_rail_receiver;
  localparam int W = 8;
  localparam int EW = 2;
  logic clk = 0, reset = 1, in_valid = 0, in_sof = 0, rail_p = 0, rail_n = 0, out_ready = 0;
  logic in_ready, out_valid, err_pulse;
  logic [W-1:0] out_data;
  logic [EW-1:0] err_count;
  int checks = 0, failures = 0;
  logic [W-1:0] exp_words[$];
  logic [EW-1:0] exp_errs[$];
  logic pv = 0, pr = 0, prst = 1;
  logic [W-1:0] pd = '0;

  dual_rail_receiver #(.WIDTH(W), .ERR_CNT_W(EW)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sof   (in_sof),
    .rail_p   (rail_p),
    .rail_n   (rail_n),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .err_pulse(err_pulse),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic p, input logic n, input logic sof);
    int t = 0;
    while (!in_ready && t < 50) begin
      step();
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", in_ready, 1);
    in_valid = 1;
    rail_p = p;
    rail_n = n;
    in_sof = sof;
    step();
    in_valid = 0;
    in_sof = 0;
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit push, input bit sof_first);
    for (int i = 0; i < W; i++) begin
      if (i == W - 1 && push) exp_words.push_back(w);
      beat(w[i], ~w[i], sof_first && i == 0);
    end
    chk("latency_out_valid", out_valid, 1);
    chk("latency_in_ready", in_ready, 0);
  endtask

  always @(negedge clk) begin
    if (err_pulse) begin
      if (exp_errs.size() == 0) chk("unexpected_err_pulse", err_pulse, 0);
      else chk("err_count_on_pulse", err_count, exp_errs.pop_front());
    end
    if (out_valid && out_ready) begin
      if (exp_words.size() == 0) chk("unexpected_word", out_valid, 0);
      else chk("out_data", out_data, exp_words.pop_front());
    end
    if (out_valid) chk("inv_valid_blocks_ready", in_ready, 0);
    if (pv && !pr && !prst) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, pd);
    end
    pv <= out_valid;
    pr <= out_ready;
    prst <= reset;
    pd <= out_data;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    step();
    step();
    reset = 0;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_err_count", err_count, 0);
    chk("reset_err_pulse", err_pulse, 0);
    chk("reset_out_data", out_data, 0);
    // word 0x4D, held by consumer
    send_word(8'h4D, 1, 1);
    chk("t1_err_count", err_count, 0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1;
      rail_p = 1;
      rail_n = 0;
      in_sof = 1;
      step();
      chk("t2_in_ready", in_ready, 0);
      chk("t2_out_data", out_data, 8'h4D);
    end
    in_valid = 0;
    in_sof = 0;
    out_ready = 1;
    step();
    chk("t2_release_valid", out_valid, 0);
    chk("t2_release_ready", in_ready, 1);
    chk("t2_data_kept", out_data, 8'h4D);
    // partial word aborted by an 11 symbol
    beat(1, 0, 1);
    beat(0, 1, 0);
    beat(1, 0, 0);
    exp_errs.push_back(1);
    beat(1, 1, 0);
    chk("t3_err_pulse", err_pulse, 1);
    chk("t3_err_count", err_count, 1);
    step();
    chk("t3_pulse_width", err_pulse, 0);
    send_word(8'hFF, 1, 0);
    // sof mid-word restarts
    beat(1, 0, 1);
    for (int i = 0; i < 4; i++) beat(0, 1, 0);
    send_word(8'hA5, 1, 1);
    chk("t4_err_count", err_count, 1);
    // reset mid-word
    beat(1, 0, 1);
    beat(1, 0, 0);
    beat(0, 1, 0);
    beat(1, 0, 0);
    reset = 1;
    step();
    reset = 0;
    chk("t6a_out_valid", out_valid, 0);
    chk("t6a_in_ready", in_ready, 1);
    chk("t6a_err_count", err_count, 0);
    chk("t6a_err_pulse", err_pulse, 0);
    chk("t6a_out_data", out_data, 0);
    send_word(8'h3C, 1, 0);
    step();
    // reset during HOLD
    out_ready = 0;
    send_word(8'hC3, 0, 1);
    step();
    chk("t6b_holding", out_valid, 1);
    reset = 1;
    step();
    reset = 0;
    chk("t6b_out_valid", out_valid, 0);
    chk("t6b_in_ready", in_ready, 1);
    chk("t6b_out_data", out_data, 0);
    chk("t6b_err_pulse", err_pulse, 0);
    out_ready = 1;
    send_word(8'h96, 1, 1);
    // back-to-back invalid symbols saturate the counter
    for (int i = 0; i < 5; i++) begin
      exp_errs.push_back(EW'(i < 3 ? i + 1 : 3));
      beat(0, 0, i == 0);
      chk("t5_err_pulse", err_pulse, 1);
    end
    step();
    chk("t5_pulse_end", err_pulse, 0);
    chk("t5_err_sat", err_count, 3);
    repeat (3) step();
    chk("words_drained", exp_words.size(), 0);
    chk("errs_drained", exp_errs.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
